axi4lite_write_fifo: RTL
========================

// Module: axi4lite_write_fifo
// PURPOSE
//  Parametrised AXI4-Lite write slave; drop-in successor to the single-shot write port.
//  Buffers AW and W channels independently, joins them, and pushes {addr,data,strb} into a FIFO.
//  Local register banks drain that FIFO using a valid/ready handshake.
//  B responses are posted at FIFO push, so the AXI master never waits on downstream consumption.
// PARAMETERS
//  ADDR_W  40  address width (awaddr, out_addr)
//  DATA_W  32  data width; a multiple of 8; STRB_W = DATA_W/8
//  DEPTH   4   command FIFO entries; a power of 2, >= 2
//  BASE    0   decode window base; used only with AXI4LITE_WRITE_DECERR_EN
//  SIZE    'h1000  decode window size in bytes; used only with AXI4LITE_WRITE_DECERR_EN
// PORTS
//  clk          in   1        sole clock; everything is on the rising edge
//  reset        in   1        synchronous, active-high reset
//  axi_awaddr   in   ADDR_W   write address
//  axi_awprot   in   3        accepted and ignored
//  axi_awvalid  in   1        AW valid
//  axi_awready  out  1        AW ready
//  axi_wdata    in   DATA_W   write data
//  axi_wstrb    in   STRB_W   byte strobes
//  axi_wvalid   in   1        W valid
//  axi_wready   out  1        W ready
//  axi_bresp    out  2        2'b00 OKAY; 2'b11 DECERR (only with the macro)
//  axi_bvalid   out  1        B valid
//  axi_bready   in   1        B ready
//  out_addr     out  ADDR_W   FIFO head address
//  out_data     out  DATA_W   FIFO head data
//  out_strb     out  STRB_W   FIFO head strobes
//  out_valid    out  1        FIFO non-empty
//  out_ready    in   1        pop the head when out_valid && out_ready
//  fifo_level   out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset:
//   - aw_full = w_full = 0, so awready = wready = 1 in the first cycle after reset.
//   - bvalid = 0, bresp = 0, FIFO empty (out_valid = 0, fifo_level = 0).
//   - Reset mid-operation discards held AW/W, any pending B, and all FIFO entries.
//  AW hold register:
//   - awready = ~aw_full, driven from the register.
//   - awvalid && awready: capture awaddr and set aw_full.
//  W hold register:
//   - wready = ~w_full.
//   - On handshake, capture wdata and wstrb and set w_full.
//   - AW and W may arrive in either order or in the same cycle. Per A3.3.1 neither waits on the other.
//  Join fires when aw_full && w_full && fifo_level<DEPTH && (~bvalid || bready):
//   - Clear aw_full and w_full.
//   - Push {addr,data,strb}; with the macro, push only when the address is in-window.
//   - Set bvalid and load bresp.
//  Latency: AW+W handshake on the same edge N gives join at N+1.
//   - bvalid and out_valid are high after edge N+1.
//   - Back-to-back throughput is 1 write per 2 cycles.
//  B channel:
//   - bvalid holds until bready.
//   - If bvalid && bready coincides with a join, bvalid stays 1 with the new bresp (no bubble).
//  FIFO:
//   - Push and pop in the same cycle when full is legal; level stays DEPTH.
//   - Pop when empty is ignored.
//   - Pointers wrap modulo DEPTH.
//  FIFO full: the join stalls, holds stay set, awready/wready stay 0. No data is lost.
//  Outputs out_* are stable while out_valid && ~out_ready.
// CONFIGURATION
//  AXI4LITE_WRITE_DECERR_EN defined:
//   - Address outside [BASE, BASE+SIZE) gives bresp=2'b11 and no FIFO push.
//   - That join ignores FIFO full.
//  Not defined:
//   - Every write is pushed and bresp is fixed at 2'b00.
//   - BASE and SIZE are unused.
// STRUCTURE
//  Package axi4lite_pkg:
//   - RESP_OKAY/RESP_SLVERR/RESP_DECERR localparams.
//   - typedef struct wr_cmd_t {addr,data,strb}; the package fixes addr/data/strb at 40/32/4 bits for the struct typedef, because a struct cannot take ADDR_W/DATA_W.
//   - The module does not use wr_cmd_t as the FIFO payload when ADDR_W/DATA_W differ from 40/32. It packs {addr,data,strb} into a local logic vector of width ADDR_W+DATA_W+STRB_W.
//  Sub-module axi4lite_sync_fifo (WIDTH, DEPTH):
//   - Register array; push/pop/full/empty/level.
//   - Instantiated once with WIDTH = ADDR_W+DATA_W+STRB_W.
// TESTING
//  1 AW 0x100 and W 0xDEADBEEF/strb F in the same cycle, bready=1, out_ready=1
//    -> bvalid after edge 2, out_addr=0x100, out_data=0xDEADBEEF.
//  2 W 0x11 three cycles before AW 0x8
//    -> wready low in between; single push {0x8,0x11}; bresp=00.
//  3 out_ready=0, DEPTH=4; issue 6 writes
//    -> fifo_level=4; awready/wready low; no B for write 6;
//    -> raise out_ready: all 6 pop in order, 6 B beats.
//  4 bready=0 with 2 writes pending -> one bvalid held, second join stalls;
//    -> bready pulse: second B follows without a bubble.
//  5 reset asserted with 3 FIFO entries and bvalid=1
//    -> next cycle out_valid=0, bvalid=0, level=0, awready=wready=1.
//  6 With the macro, BASE=0x1000, SIZE=0x100: AW 0x2000
//    -> bresp=2'b11, no push, level unchanged.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite write slave: response codes and the
// nominal write-command record used by the rest of the codebase.
package axi4lite_pkg;

  // AXI write response encodings.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Field widths of the nominal command record.
  localparam int unsigned CMD_ADDR_W = 40;
  localparam int unsigned CMD_DATA_W = 32;
  localparam int unsigned CMD_STRB_W = CMD_DATA_W / 8;

  // Nominal write command. A struct cannot follow module parameters, so the
  // widths here are fixed; parametrised users pack a plain vector instead.
  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_STRB_W-1:0] strb;
  } wr_cmd_t;

endpackage

// File: rtl/axi4lite_sync_fifo.sv
// Single-clock FIFO built on a register array. Push into a full FIFO is
// accepted only when a pop happens on the same edge; pop when empty is ignored.
// DEPTH must be a power of two so the pointers wrap for free.
module axi4lite_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned    PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_MAX = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == LVL_MAX);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (PTR_W + 1)'(1);
      2'b01:   level_d = level_q - (PTR_W + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is not reset; an entry is only read after it has been
    // written, and clearing the pointers is enough to empty the FIFO.
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/axi4lite_write_fifo.sv
// AXI4-Lite write slave. AW and W are captured in independent hold registers,
// joined into one command and pushed into a command FIFO drained by the local
// register banks. The B response is posted when the command is pushed.
// Optional feature: define AXI4LITE_WRITE_DECERR_EN to answer writes outside
// [BASE, BASE+SIZE) with DECERR and drop them instead of pushing.
module axi4lite_write_fifo
  import axi4lite_pkg::*;
#(
  parameter int unsigned       ADDR_W = 40,
  parameter int unsigned       DATA_W = 32,
  parameter int unsigned       DEPTH  = 4,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W:0]   SIZE   = 'h1000
) (
  input  logic                      clk,
  input  logic                      reset,
  // AW channel
  input  logic [ADDR_W-1:0]         axi_awaddr,
  input  logic [2:0]                axi_awprot,
  input  logic                      axi_awvalid,
  output logic                      axi_awready,
  // W channel
  input  logic [DATA_W-1:0]         axi_wdata,
  input  logic [DATA_W/8-1:0]       axi_wstrb,
  input  logic                      axi_wvalid,
  output logic                      axi_wready,
  // B channel
  output logic [1:0]                axi_bresp,
  output logic                      axi_bvalid,
  input  logic                      axi_bready,
  // Command FIFO head
  output logic [ADDR_W-1:0]         out_addr,
  output logic [DATA_W-1:0]         out_data,
  output logic [DATA_W/8-1:0]       out_strb,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CMD_W  = ADDR_W + DATA_W + STRB_W;

  // Hold registers
  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q,  w_full_d;
  logic [DATA_W-1:0] w_data_q,  w_data_d;
  logic [STRB_W-1:0] w_strb_q,  w_strb_d;

  // B channel registers
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q,  bresp_d;

  // Join and FIFO interface
  logic              aw_hs, w_hs;
  logic              in_window;
  logic              b_free;
  logic              join_fire;
  logic              push;
  logic              fifo_full, fifo_empty;
  logic [CMD_W-1:0]  push_cmd, head_cmd;
  logic              unused_cfg;

  assign axi_awready = ~aw_full_q;
  assign axi_wready  = ~w_full_q;
  assign aw_hs       = axi_awvalid && ~aw_full_q;
  assign w_hs        = axi_wvalid  && ~w_full_q;

`ifdef AXI4LITE_WRITE_DECERR_EN
  // Window check done one bit wider so BASE+SIZE cannot overflow.
  assign in_window  = (aw_addr_q >= BASE) &&
                      ({1'b0, aw_addr_q} < ({1'b0, BASE} + SIZE));
  assign unused_cfg = ^axi_awprot;
`else
  assign in_window  = 1'b1;
  assign unused_cfg = ^{axi_awprot, BASE, SIZE};
`endif

  // The B slot is free if empty or being emptied on this edge. An
  // out-of-window write never touches the FIFO, so FIFO full cannot stall it.
  assign b_free    = ~bvalid_q || axi_bready;
  assign join_fire = aw_full_q && w_full_q && b_free && (~fifo_full || ~in_window);
  assign push      = join_fire && in_window;
  assign push_cmd  = {aw_addr_q, w_data_q, w_strb_q};

  // Hold-register next state: capture on handshake, release on join.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (join_fire) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_addr_d = axi_awaddr;
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = axi_wdata;
        w_strb_d = axi_wstrb;
      end
    end
  end

  // B channel next state: a join reloads the slot, so a coincident bready
  // does not open a bubble.
  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (join_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = in_window ? RESP_OKAY : RESP_DECERR;
    end else if (axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Control flags; reset discards held commands and any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Payload registers; only meaningful while the matching full flag is set.
  always_ff @(posedge clk) begin
    aw_addr_q <= aw_addr_d;
    w_data_q  <= w_data_d;
    w_strb_q  <= w_strb_d;
  end

  axi4lite_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_cmd),
    .pop_i       (out_ready),
    .pop_data_o  (head_cmd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign {out_addr, out_data, out_strb} = head_cmd;
  assign out_valid  = ~fifo_empty;
  assign axi_bvalid = bvalid_q;
  assign axi_bresp  = bresp_q;

endmodule
